// File: rtl/checksum_pkg.sv
// ============================================================================
// Module : checksum_pkg
// Brief  : Shared state encoding and mode constants for the checksum frame sequencer.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package checksum_pkg;

  typedef enum logic [2:0] {
    CLR      = 3'd0,
    IDLE     = 3'd1,
    ACCUM    = 3'd2,
    CALC     = 3'd3,
    WAIT_RDY = 3'd4,
    APPEND   = 3'd5,
    RESULT   = 3'd6
  } state_t;

  localparam logic MODE_GEN = 1'b0;
  localparam logic MODE_VER = 1'b1;

endpackage

`default_nettype wire

// File: rtl/checksum_frame_ctrl.sv
// ============================================================================
// Module : checksum_frame_ctrl
// Brief  : Inline frame sequencer for checksum_core: streams words, appends or checks the sum.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module checksum_frame_ctrl
  import checksum_pkg::*;
#(
  parameter int p_WORD_LEN  = 8,
  parameter int p_MAX_WORDS = 255,
  parameter int p_TIMEOUT   = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_mode,
  input  logic [p_WORD_LEN-1:0] i_in_data,
  input  logic                  i_in_valid,
  input  logic                  i_in_last,
  output logic                  o_in_rdy,
  output logic [p_WORD_LEN-1:0] o_out_data,
  output logic                  o_out_valid,
  output logic                  o_out_last,
  input  logic                  i_out_rdy,
  output logic                  o_core_rst,
  output logic                  o_core_en,
  output logic [p_WORD_LEN-1:0] o_core_data,
  output logic                  o_core_calc,
  input  logic [p_WORD_LEN-1:0] i_core_sum,
  input  logic                  i_core_rdy,
  output logic                  o_pass,
  output logic                  o_fail,
  output logic                  o_err
);

  localparam int c_CNT_W = $clog2(p_MAX_WORDS + 2);
  localparam int c_TMO_W = $clog2(p_TIMEOUT + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(p_MAX_WORDS);
  localparam logic [c_TMO_W-1:0] c_TMO_MAX = c_TMO_W'(p_TIMEOUT);

  state_t                r_state;
  state_t                w_next;
  logic [c_CNT_W-1:0]    r_cnt;
  logic [c_TMO_W-1:0]    r_tmo;
  logic                  r_mode;
  logic [p_WORD_LEN-1:0] r_sum;
  logic                  w_xfer;
  logic                  w_mode_eff;
  logic                  w_over;
  logic                  w_tmo_hit;

  // The first word of a frame has not latched its mode yet, so use the live input.
  assign w_mode_eff = (r_state == IDLE) ? i_mode : r_mode;
  assign w_over     = (r_cnt >= c_CNT_MAX);
  assign w_tmo_hit  = (r_tmo == c_TMO_MAX);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= CLR;
      r_cnt   <= '0;
      r_tmo   <= '0;
      r_mode  <= MODE_GEN;
      r_sum   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        CLR: begin
          r_cnt <= '0;
          r_tmo <= '0;
        end
        IDLE, ACCUM: begin
          if (w_xfer) begin
            r_cnt <= r_cnt + c_CNT_W'(1);
            if (r_state == IDLE) r_mode <= i_mode;
          end
        end
        WAIT_RDY: begin
          if (i_core_rdy) r_sum <= i_core_sum;
          else if (!w_tmo_hit) r_tmo <= r_tmo + c_TMO_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next      = r_state;
    w_xfer      = 1'b0;
    o_in_rdy    = 1'b0;
    o_out_data  = '0;
    o_out_valid = 1'b0;
    o_out_last  = 1'b0;
    o_core_rst  = 1'b0;
    o_core_en   = 1'b0;
    o_core_data = '0;
    o_core_calc = 1'b0;
    o_pass      = 1'b0;
    o_fail      = 1'b0;
    o_err       = 1'b0;
    case (r_state)
      CLR: begin
        o_core_rst = 1'b1;
        w_next     = IDLE;
      end
      IDLE, ACCUM: begin
        o_out_data  = i_in_data;
        o_out_valid = i_in_valid;
        o_in_rdy    = i_out_rdy;
        // In generate mode the appended checksum carries last instead.
        o_out_last  = (w_mode_eff == MODE_VER) && i_in_last;
        w_xfer      = i_in_valid && i_out_rdy;
        if (w_xfer) begin
          o_core_en   = 1'b1;
          o_core_data = i_in_data;
          if (i_in_last) begin
            w_next = CALC;
          end else if (w_over) begin
            o_err  = 1'b1;
            w_next = CLR;
          end else begin
            w_next = ACCUM;
          end
        end
      end
      CALC: begin
        o_core_calc = 1'b1;
        w_next      = WAIT_RDY;
      end
      WAIT_RDY: begin
        if (i_core_rdy) begin
          w_next = (r_mode == MODE_GEN) ? APPEND : RESULT;
        end else if (w_tmo_hit) begin
          o_err  = 1'b1;
          w_next = CLR;
        end
      end
      APPEND: begin
        o_out_data  = r_sum;
        o_out_valid = 1'b1;
        o_out_last  = 1'b1;
        if (i_out_rdy) w_next = CLR;
      end
      RESULT: begin
        o_pass = (r_sum == '0);
        o_fail = (r_sum != '0);
        w_next = CLR;
      end
      default: w_next = CLR;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_checksum_frame_ctrl.sv
// ============================================================================
// Module : tb_checksum_frame_ctrl
// Brief  : Directed bench for checksum_frame_ctrl with a ones-complement core model alongside.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_checksum_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_mode = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       o_in_rdy;
  logic [7:0] o_out_data;
  logic       o_out_valid;
  logic       o_out_last;
  logic       out_rdy = 1'b0;
  logic       out_rdy_base = 1'b1;
  logic       bp_en = 1'b0;
  logic       core_rst;
  logic       core_en;
  logic [7:0] core_data;
  logic       core_calc;
  logic [7:0] core_sum;
  logic       core_rdy;
  logic       o_pass;
  logic       o_fail;
  logic       o_err;

  logic [7:0] core_acc;
  logic       core_rdy_q;
  logic       core_allow = 1'b1;

  int errors = 0;
  int checks = 0;
  logic [8:0] mon_q[$];

  always #5 clk = ~clk;

  checksum_frame_ctrl #(
    .p_WORD_LEN (8),
    .p_MAX_WORDS(8),
    .p_TIMEOUT  (16)
  ) dut (
    .i_clk      (clk),
    .i_reset    (rst_n),
    .i_mode     (in_mode),
    .i_in_data  (in_data),
    .i_in_valid (in_valid),
    .i_in_last  (in_last),
    .o_in_rdy   (o_in_rdy),
    .o_out_data (o_out_data),
    .o_out_valid(o_out_valid),
    .o_out_last (o_out_last),
    .i_out_rdy  (out_rdy),
    .o_core_rst (core_rst),
    .o_core_en  (core_en),
    .o_core_data(core_data),
    .o_core_calc(core_calc),
    .i_core_sum (core_sum),
    .i_core_rdy (core_rdy),
    .o_pass     (o_pass),
    .o_fail     (o_fail),
    .o_err      (o_err)
  );

  // Ones-complement checksum core: end-around-carry add, ready one cycle after calc.
  function automatic logic [7:0] oc_add(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[7:0] + {7'd0, s[8]};
  endfunction

  always_ff @(posedge clk) begin
    if (core_rst) begin
      core_acc   <= '0;
      core_rdy_q <= 1'b0;
    end else begin
      if (core_en) core_acc <= oc_add(core_acc, core_data);
      if (core_calc) core_rdy_q <= 1'b1;
    end
  end
  assign core_sum = ~core_acc;
  assign core_rdy = core_rdy_q & core_allow;

  always @(posedge clk) begin
    #2;
    out_rdy = bp_en ? ~out_rdy : out_rdy_base;
  end

  always @(negedge clk) begin
    if (rst_n && o_out_valid && out_rdy) mon_q.push_back({o_out_last, o_out_data});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic send(input logic [7:0] d, input logic last, input logic exp_last,
                      input logic exp_err);
    int n;
    n        = 0;
    in_data  = d;
    in_valid = 1'b1;
    in_last  = last;
    #1;
    while (!o_in_rdy && n < 100) begin
      check("stall_no_en", 32'(core_en), 32'd0);
      @(posedge clk);
      #4;
      n++;
    end
    check("in_rdy_wait", 32'(n < 100), 32'd1);
    check("pt_data", 32'(o_out_data), 32'(d));
    check("pt_valid", 32'(o_out_valid), 32'd1);
    check("pt_last", 32'(o_out_last), 32'(exp_last));
    check("core_en", 32'(core_en), 32'd1);
    check("core_data", 32'(core_data), 32'(d));
    check("len_err", 32'(o_err), 32'(exp_err));
    @(posedge clk);
    #3;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic gen_frame_f5();
    in_mode = 1'b0;
    send(8'h01, 1'b0, 1'b0, 1'b0);
    send(8'h02, 1'b0, 1'b0, 1'b0);
    send(8'h03, 1'b0, 1'b0, 1'b0);
    send(8'h04, 1'b1, 1'b0, 1'b0);
    check("calc_pulse", 32'(core_calc), 32'd1);
    check("calc_in_rdy", 32'(o_in_rdy), 32'd0);
    check("calc_out_valid", 32'(o_out_valid), 32'd0);
    step();
    check("wait_in_rdy", 32'(o_in_rdy), 32'd0);
    step();
    check("append_valid", 32'(o_out_valid), 32'd1);
    check("append_data", 32'(o_out_data), 32'hF5);
    check("append_last", 32'(o_out_last), 32'd1);
    step();
    check("clr_core_rst", 32'(core_rst), 32'd1);
    check("clr_out_valid", 32'(o_out_valid), 32'd0);
    step();
  endtask

  initial begin
    int n;
    logic [8:0] exp_words [5];
    exp_words[0] = 9'h001;
    exp_words[1] = 9'h002;
    exp_words[2] = 9'h003;
    exp_words[3] = 9'h004;
    exp_words[4] = 9'h1F5;

    // Reset state
    step();
    step();
    check("rst_core_rst", 32'(core_rst), 32'd1);
    check("rst_in_rdy", 32'(o_in_rdy), 32'd0);
    check("rst_out_valid", 32'(o_out_valid), 32'd0);
    check("rst_pulses", {29'd0, o_pass, o_fail, o_err}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("post_rst_clr", 32'(core_rst), 32'd1);
    step();

    // Generate frame
    gen_frame_f5();

    // Verify good frame; mode changes after first word must be ignored
    in_mode = 1'b1;
    send(8'h01, 1'b0, 1'b0, 1'b0);
    in_mode = 1'b0;
    send(8'h02, 1'b0, 1'b0, 1'b0);
    send(8'h03, 1'b0, 1'b0, 1'b0);
    send(8'h04, 1'b0, 1'b0, 1'b0);
    send(8'hF5, 1'b1, 1'b1, 1'b0);
    step();
    step();
    check("vgood_pass", 32'(o_pass), 32'd1);
    check("vgood_fail", 32'(o_fail), 32'd0);
    step();
    check("vgood_pass_once", 32'(o_pass), 32'd0);
    step();

    // Verify bad frame
    in_mode = 1'b1;
    send(8'h01, 1'b0, 1'b0, 1'b0);
    send(8'h02, 1'b0, 1'b0, 1'b0);
    send(8'h03, 1'b0, 1'b0, 1'b0);
    send(8'h04, 1'b0, 1'b0, 1'b0);
    send(8'hF4, 1'b1, 1'b1, 1'b0);
    step();
    step();
    check("vbad_fail", 32'(o_fail), 32'd1);
    check("vbad_pass", 32'(o_pass), 32'd0);
    step();
    check("vbad_fail_once", 32'(o_fail), 32'd0);
    step();

    // Backpressure generate frame
    mon_q.delete();
    in_mode = 1'b0;
    bp_en   = 1'b1;
    send(8'h01, 1'b0, 1'b0, 1'b0);
    send(8'h02, 1'b0, 1'b0, 1'b0);
    send(8'h03, 1'b0, 1'b0, 1'b0);
    send(8'h04, 1'b1, 1'b0, 1'b0);
    #1;
    n = 0;
    while (!o_out_valid && n < 20) begin
      @(posedge clk);
      #4;
      n++;
    end
    check("bp_append_seen", 32'(n < 20), 32'd1);
    check("bp_append_data", 32'(o_out_data), 32'hF5);
    check("bp_append_last", 32'(o_out_last), 32'd1);
    n = 0;
    while (!out_rdy && n < 20) begin
      @(posedge clk);
      #4;
      n++;
      check("bp_hold_valid", 32'(o_out_valid), 32'd1);
      check("bp_hold_data", 32'(o_out_data), 32'hF5);
    end
    @(posedge clk);
    #3;
    check("bp_clr", 32'(core_rst), 32'd1);
    bp_en = 1'b0;
    step();
    step();
    check("bp_word_count", 32'(mon_q.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < mon_q.size()) check("bp_word", 32'(mon_q[i]), 32'(exp_words[i]));
    end

    // Timeout: core never reports ready
    core_allow = 1'b0;
    in_mode    = 1'b0;
    send(8'h01, 1'b1, 1'b0, 1'b0);
    step();
    check("tmo_entry_err", 32'(o_err), 32'd0);
    n = 0;
    while (n < 40) begin
      step();
      n++;
      if (o_err) break;
    end
    check("tmo_cycles", 32'(n), 32'd16);
    step();
    check("tmo_err_once", 32'(o_err), 32'd0);
    check("tmo_clr", 32'(core_rst), 32'd1);
    core_allow = 1'b1;
    step();

    // Length overflow: nine words, no last
    for (int i = 0; i < 8; i++) send(8'(i + 1), 1'b0, 1'b0, 1'b0);
    send(8'h09, 1'b0, 1'b0, 1'b1);
    check("ovf_clr", 32'(core_rst), 32'd1);
    check("ovf_err_once", 32'(o_err), 32'd0);
    step();

    // Reset mid-frame
    send(8'h01, 1'b0, 1'b0, 1'b0);
    send(8'h02, 1'b0, 1'b0, 1'b0);
    in_data  = 8'h03;
    in_valid = 1'b1;
    rst_n    = 1'b0;
    #1;
    check("mid_rst_core_rst", 32'(core_rst), 32'd1);
    check("mid_rst_in_rdy", 32'(o_in_rdy), 32'd0);
    check("mid_rst_out_valid", 32'(o_out_valid), 32'd0);
    check("mid_rst_core_en", 32'(core_en), 32'd0);
    check("mid_rst_pulses", {29'd0, o_pass, o_fail, o_err}, 32'd0);
    step();
    in_valid = 1'b0;
    rst_n    = 1'b1;
    step();
    gen_frame_f5();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
